// File: rtl/rf_write_ctrl.sv
// Register-file write-port arbiter: zero-fills the file after reset, then merges
// pipeline writeback (strict priority) with a 2-deep buffer of multi-cycle unit results.
module rf_write_ctrl #(
    parameter int CLEAR_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    output logic        busy,
    output logic [1:0]  pend_cnt,
    output logic        fsm_state
);

    // MDU handshake: a result transfers on the posedge where mdu_valid and
    // mdu_ready are both 1; mdu_valid must hold with stable addr/data until then.

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_EN != 0) ? S_CLEAR : S_RUN;

    state_t      state;
    logic [4:0]  clr_cnt;
    logic [1:0]  cnt;
    logic [36:0] fifo0;
    logic [36:0] fifo1;

    logic        wb_sel;
    logic        pop;
    logic        push;
    logic [1:0]  level_after_pop;

    assign wb_sel    = wb_we && (wb_addr != 5'd0);
    assign mdu_ready = !rst && (state == S_RUN) && (cnt != 2'd2);
    assign pop       = !rst && (state == S_RUN) && !wb_sel && (cnt != 2'd0);
    assign push      = mdu_valid && mdu_ready && (mdu_addr != 5'd0);
    assign busy      = rst || (state == S_CLEAR);
    assign pend_cnt  = cnt;
    assign fsm_state = state;

    assign level_after_pop = cnt - {1'b0, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RST_STATE;
            clr_cnt <= 5'd0;
            cnt     <= 2'd0;
            fifo0   <= '0;
            fifo1   <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 5'd1;
                    if (clr_cnt == 5'd31) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (pop) begin
                        fifo0 <= fifo1;
                    end
                    // The push lands in the slot that is free after this cycle's pop.
                    if (push) begin
                        if (level_after_pop == 2'd0) begin
                            fifo0 <= {mdu_addr, mdu_data};
                        end else begin
                            fifo1 <= {mdu_addr, mdu_data};
                        end
                    end
                    cnt <= cnt + {1'b0, push} - {1'b0, pop};
                end
                default: state <= RST_STATE;
            endcase
        end
    end

    always_comb begin
        rf_we   = 1'b0;
        rf_addr = 5'd0;
        rf_data = 32'd0;
        if (!rst) begin
            if (state == S_CLEAR) begin
                rf_we   = 1'b1;
                rf_addr = clr_cnt;
            end else if (wb_sel) begin
                rf_we   = 1'b1;
                rf_addr = wb_addr;
                rf_data = wb_data;
            end else if (cnt != 2'd0) begin
                rf_we   = 1'b1;
                rf_addr = fifo0[36:32];
                rf_data = fifo0[31:0];
            end
        end
    end

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Scoreboard bench for rf_write_ctrl: the driver predicts each cycle's port
// and status from a queue model; a negedge monitor pops and compares.
module tb_rf_write_ctrl;

    localparam int W = 42; // {busy, ready, pend[1:0], we, addr[4:0], data[31:0]}

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;

    logic        mdu_ready, rf_we, busy, fsm_state;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [1:0]  pend_cnt;

    logic        mdu_ready0, rf_we0, busy0, fsm_state0;
    logic [4:0]  rf_addr0;
    logic [31:0] rf_data0;
    logic [1:0]  pend_cnt0;

    rf_write_ctrl #(.CLEAR_EN(1)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .busy(busy), .pend_cnt(pend_cnt), .fsm_state(fsm_state)
    );

    rf_write_ctrl #(.CLEAR_EN(0)) dut0 (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready0), .rf_we(rf_we0), .rf_addr(rf_addr0), .rf_data(rf_data0),
        .busy(busy0), .pend_cnt(pend_cnt0), .fsm_state(fsm_state0)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [36:0]  mq[$];     // model of buffered MDU results, oldest first
    int           clr_left;
    int           tests;
    int           fails;
    int           mon_cyc;
    logic         hv;
    logic [4:0]   ha;
    logic [31:0]  hd;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         output logic acc);
        logic [36:0] head;
        int          sz;
        logic        rdy;
        logic        ew;
        logic [4:0]  ea;
        logic [31:0] ed;
        wb_we     = we;
        wb_addr   = wa;
        wb_data   = wd;
        mdu_valid = mv;
        mdu_addr  = ma;
        mdu_data  = md;
        acc = 1'b0;
        ew  = 1'b0;
        ea  = 5'd0;
        ed  = 32'd0;
        if (clr_left > 0) begin
            ew = 1'b1;
            ea = 5'(32 - clr_left);
            clr_left--;
            exp_q.push_back({1'b1, 1'b0, 2'd0, ew, ea, ed});
        end else begin
            sz  = mq.size();
            rdy = (sz < 2);
            if (we && wa != 5'd0) begin
                ew = 1'b1; ea = wa; ed = wd;
            end else if (sz > 0) begin
                head = mq.pop_front();
                ew = 1'b1; ea = head[36:32]; ed = head[31:0];
            end
            exp_q.push_back({1'b0, rdy, 2'(sz), ew, ea, ed});
            acc = mv && rdy;
            if (acc && ma != 5'd0) mq.push_back({ma, md});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        wb_we     = 1'b0;
        mdu_valid = 1'b0;
        mq.delete();
        clr_left  = 32;
        hv        = 1'b0;
        repeat (n) begin
            exp_q.push_back({1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 32'd0});
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic rand_cycles(input int n, input int wb_pct);
        logic acc;
        logic we;
        for (int i = 0; i < n; i++) begin
            if (!hv && $urandom_range(0, 1) == 1) begin
                hv = 1'b1;
                ha = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                hd = $urandom;
            end
            we = ($urandom_range(0, 99) < wb_pct);
            cycle(we, 5'($urandom_range(0, 31)), $urandom, hv, ha, hd, acc);
            if (acc) hv = 1'b0;
        end
    endtask

    task automatic clear_cycles(input int n);
        logic acc;
        for (int i = 0; i < n; i++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), $urandom, acc);
        end
    endtask

    task automatic idle_cycles(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        mon_cyc = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = {busy, mdu_ready, pend_cnt, rf_we,
                       rf_we ? rf_addr : 5'd0, rf_we ? rf_data : 32'd0};
                check($sformatf("cyc%0d port/status", mon_cyc), act, exp);
                if (rst) begin
                    check($sformatf("cyc%0d noclear reset outputs", mon_cyc),
                          W'({busy0, mdu_ready0, pend_cnt0, rf_we0}), W'(5'b1_0_00_0));
                end
                mon_cyc++;
            end
        end
    end

    // Without the clear sequence the block must be live on the first cycle.
    initial begin
        @(negedge rst);
        @(negedge clk);
        check("noclear first cycle busy/ready/pend",
              W'({busy0, mdu_ready0, pend_cnt0}), W'(4'b0_1_00));
    end

    // ---------------- main sequence ----------------
    initial begin
        logic acc;
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        wb_we     = 1'b0;
        wb_addr   = 5'd0;
        wb_data   = 32'd0;
        mdu_valid = 1'b0;
        mdu_addr  = 5'd0;
        mdu_data  = 32'd0;
        hv        = 1'b0;
        ha        = 5'd0;
        hd        = 32'd0;
        clr_left  = 0;
        @(posedge clk);
        #1;

        do_reset(2);
        clear_cycles(32);
        idle_cycles(2);

        // Writeback holds the port for 3 cycles while one MDU result waits.
        cycle(1'b1, 5'd5, 32'h0000_0055, 1'b1, 5'd7, 32'hDEAD_BEEF, acc);
        cycle(1'b1, 5'd5, 32'h0000_0056, 1'b0, 5'd0, 32'd0, acc);
        cycle(1'b1, 5'd5, 32'h0000_0057, 1'b0, 5'd0, 32'd0, acc);
        idle_cycles(3);

        // Fill both slots under writeback, third result held on valid until accepted.
        cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hAAAA_0001, acc);
        cycle(1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'hBBBB_0002, acc);
        acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic a;
            cycle(i < 2, 5'(3 + i), 32'(i), !acc, 5'd12, 32'hCCCC_0003, a);
            if (a) acc = 1'b1;
        end
        idle_cycles(2);

        // Dropped writeback to r0 lets the buffered result through; r0 push is discarded.
        cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd3, 32'h11, acc);
        cycle(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h77, acc);
        idle_cycles(2);

        // Reset in the middle of the clear, then with both slots full.
        do_reset(1);
        clear_cycles(10);
        do_reset(1);
        clear_cycles(32);
        cycle(1'b1, 5'd4, 32'h4, 1'b1, 5'd20, 32'h2020_2020, acc);
        cycle(1'b1, 5'd4, 32'h4, 1'b1, 5'd21, 32'h2121_2121, acc);
        cycle(1'b1, 5'd4, 32'h4, 1'b0, 5'd0, 32'd0, acc);
        do_reset(2);
        clear_cycles(32);
        idle_cycles(4);

        rand_cycles(300, 60);
        rand_cycles(200, 20);
        do_reset(1);
        clear_cycles(5);
        do_reset(1);
        clear_cycles(32);
        rand_cycles(200, 75);
        idle_cycles(4);

        @(negedge clk);
        #1;
        check("scoreboard drained", W'(exp_q.size()), W'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_write_ctrl.md
RF_WRITE_CTRL -- requirements
Module: rf_write_ctrl

Interface
REQ-001 The block SHALL have parameter CLEAR_EN, default 1, meaning: 1 = zero all 32 registers after reset; 0 = skip the clear sequence.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  system clock; state updates on posedge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 wb_we  input  1  pipeline writeback write request.
REQ-006 wb_addr  input  5  pipeline writeback destination register.
REQ-007 wb_data  input  32  pipeline writeback data.
REQ-008 mdu_valid  input  1  multi-cycle unit result valid.
REQ-009 mdu_addr  input  5  multi-cycle unit destination register.
REQ-010 mdu_data  input  32  multi-cycle unit result data.
REQ-011 mdu_ready  output  1  result buffer can accept; transfer occurs on posedge when mdu_valid and mdu_ready are both 1.
REQ-012 rf_we  output  1  drives register file RegWrite.
REQ-013 rf_addr  output  5  drives register file RdAddr.
REQ-014 rf_data  output  32  drives register file RdData.
REQ-015 busy  output  1  clear sequence or reset in progress; pipeline stalls while 1.
REQ-016 pend_cnt  output  2  number of buffered MDU results (0..2).

Function
REQ-017 The block SHALL implement states CLEAR and RUN; it enters CLEAR from reset if CLEAR_EN=1, otherwise RUN.
REQ-018 In CLEAR, the block SHALL drive rf_we=1, rf_addr=clr_cnt, rf_data=0 combinationally; clr_cnt increments 0..31 each posedge; on the posedge with clr_cnt=31 it moves to RUN, so the clear takes exactly 32 cycles.
REQ-019 In CLEAR, the block SHALL keep busy=1 and mdu_ready=0, and SHALL ignore wb_we; in RUN busy=0.
REQ-020 The block SHALL hold a 2-entry FIFO of {addr, data} for MDU results; mdu_ready=1 exactly when state=RUN and pend_cnt<2.
REQ-021 An accepted MDU result with mdu_addr=0 SHALL be discarded and not enqueued, while the handshake still completes.
REQ-022 In RUN, port selection is combinational: if wb_we=1 and wb_addr!=0, the port carries the wb triple; else if the FIFO is non-empty, it carries the FIFO head with rf_we=1, and the head pops on the next posedge; else rf_we=0.
REQ-023 If wb_we=1 with wb_addr=0, the write SHALL be dropped, and the FIFO head may use the port that cycle.
REQ-024 Writeback SHALL have strict priority; an MDU result is never dropped and waits in the FIFO until a free cycle.
REQ-025 An MDU result accepted at posedge N SHALL appear on rf_* no earlier than cycle N+1; there is no bypass from mdu_* to rf_*.
REQ-026 Simultaneous push and pop in one posedge SHALL leave pend_cnt unchanged and preserve FIFO order.
REQ-027 With pend_cnt=2, no push can occur because mdu_ready=0; a pop in that cycle raises mdu_ready in the next cycle, not combinationally.
REQ-028 When idle, rf_addr and rf_data are don't-care, but rf_we SHALL be 0.

Reset
REQ-029 While rst=1, the block SHALL drive rf_we=0, busy=1, mdu_ready=0, pend_cnt=0, clr_cnt=0, and empty the FIFO, with state=CLEAR if CLEAR_EN=1, else RUN.
REQ-030 Reset asserted mid-clear or mid-drain SHALL discard all buffered results immediately; after deassertion, the clear restarts from register 0.
REQ-031 With CLEAR_EN=0, busy SHALL be 0 on the first cycle after rst deasserts.

Verification
REQ-032 Release rst with CLEAR_EN=1 -> 32 consecutive cycles of rf_we=1, rf_addr 0..31, rf_data=0, busy=1; then busy=0, mdu_ready=1.
REQ-033 In RUN with wb_we=1 held for 3 cycles (addr 5), push MDU {addr 7, 0xDEADBEEF} -> pend_cnt=1; rf_* carries 7/0xDEADBEEF in the first cycle with wb_we=0; pend_cnt then returns to 0.
REQ-034 Push 2 MDU results during wb_we=1 -> mdu_ready=0 and pend_cnt=2; a third result waits in valid-hold; results drain in order A, B, then C is accepted.
REQ-035 Drive wb_we=1 with wb_addr=0 while the FIFO holds {3, 0x11} -> rf_we=1, rf_addr=3; push mdu_addr=0 -> handshake completes and pend_cnt is unchanged.
REQ-036 Assert rst at clear cycle 10, and again with pend_cnt=2 -> outputs match REQ-029 immediately; the clear restarts at addr 0 and no stale result is written.
